mem_bus_ctrl: RTL and testbench

- Memory-side stage directly downstream of the SLC-3 control unit.
- Consumes the active-low Mem_CE/Mem_OE/Mem_WE/Mem_UB/Mem_LB strobes plus the MAR address and MDR write data, and sequences real async-SRAM bus cycles with programmable wait states.
- Decodes the memory-mapped I/O word (switch read, optional hex-display write) and returns read data to the MDR path, with a one-cycle completion pulse.

---
 rtl/mem_bus_ctrl.sv | 162 ++++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: turns SLC-3 control-unit strobes into async-SRAM bus cycles with wait states,
// and serves the memory-mapped I/O word. Define IO_HEX_EN to add the HEX_out display register.
module mem_bus_ctrl #(
   parameter int unsigned WAIT_CYCLES = 1,
   parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        Mem_CE,
   input  logic        Mem_OE,
   input  logic        Mem_WE,
   input  logic        Mem_UB,
   input  logic        Mem_LB,
   input  logic [15:0] ADDR,
   input  logic [15:0] Data_from_CPU,
   input  logic [15:0] Switches,
   output logic [15:0] Data_to_CPU,
   output logic        Mem_ready,
   output logic        Busy,
   output logic        Req_dropped,
   output logic [19:0] SRAM_ADDR,
   input  logic [15:0] SRAM_DQ_in,
   output logic [15:0] SRAM_DQ_out,
   output logic        SRAM_DQ_oe,
   output logic        SRAM_CE_N,
   output logic        SRAM_OE_N,
   output logic        SRAM_WE_N,
   output logic        SRAM_UB_N,
   output logic        SRAM_LB_N
`ifdef IO_HEX_EN
   ,
   output logic [15:0] HEX_out
`endif
);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] RD_ACC   = 3'd1;
   localparam logic [2:0] WR_SETUP = 3'd2;
   localparam logic [2:0] WR_PULSE = 3'd3;
   localparam logic [2:0] WR_HOLD  = 3'd4;
   localparam logic [2:0] DONE     = 3'd5;

   localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYCLES);

   logic [2:0] state;
   logic [2:0] state_nx;
   logic [2:0] wait_cnt;
   logic       prev_oe;
   logic       prev_we;
   logic       ub_en;
   logic       lb_en;
   logic       rd_req;
   logic       wr_req;
   logic       any_req;
   logic       accept;
   logic       io_hit;
   logic       io_wr;
   logic       active_nx;
   logic       ub_sel;
   logic       lb_sel;

   // Requests are falling edges of the strobes, so a held level never starts a second cycle
   assign rd_req  = ~Mem_CE & prev_oe & ~Mem_OE;
   assign wr_req  = ~Mem_CE & prev_we & ~Mem_WE;
   assign any_req = rd_req | wr_req;
   assign accept  = (state == IDLE) & any_req;
   assign io_hit  = (ADDR == IO_ADDR);

`ifdef IO_HEX_EN
   assign io_wr = io_hit;
`else
   assign io_wr = 1'b0;
`endif

   assign Busy      = (state != IDLE);
   assign active_nx = (state_nx == RD_ACC) | (state_nx == WR_SETUP) |
                      (state_nx == WR_PULSE) | (state_nx == WR_HOLD);
   assign ub_sel    = accept ? ~Mem_UB : ub_en;
   assign lb_sel    = accept ? ~Mem_LB : lb_en;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (wr_req)
               state_nx = io_wr ? DONE : WR_SETUP;
            else if (rd_req)
               state_nx = io_hit ? DONE : RD_ACC;
         end
         RD_ACC:   if (wait_cnt == 3'd0) state_nx = DONE;
         WR_SETUP: state_nx = WR_PULSE;
         WR_PULSE: if (wait_cnt == 3'd0) state_nx = WR_HOLD;
         WR_HOLD:  state_nx = DONE;
         DONE:     state_nx = IDLE;
         default:  state_nx = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state    <= IDLE;
         wait_cnt <= 3'd0;
         prev_oe  <= 1'b1;
         prev_we  <= 1'b1;
      end else begin
         state   <= state_nx;
         prev_oe <= Mem_OE;
         prev_we <= Mem_WE;
         if (state_nx != state)
            wait_cnt <= WAIT_INIT;
         else if (wait_cnt != 3'd0)
            wait_cnt <= wait_cnt - 3'd1;
      end
   end

   // Pin values are decoded from the next state so every SRAM control leaves a flop
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         SRAM_ADDR   <= 20'h00000;
         SRAM_DQ_out <= 16'h0000;
         SRAM_DQ_oe  <= 1'b0;
         SRAM_CE_N   <= 1'b1;
         SRAM_OE_N   <= 1'b1;
         SRAM_WE_N   <= 1'b1;
         SRAM_UB_N   <= 1'b1;
         SRAM_LB_N   <= 1'b1;
         ub_en       <= 1'b0;
         lb_en       <= 1'b0;
         Data_to_CPU <= 16'h0000;
         Mem_ready   <= 1'b0;
         Req_dropped <= 1'b0;
`ifdef IO_HEX_EN
         HEX_out     <= 16'h0000;
`endif
      end else begin
         if (accept) begin
            SRAM_ADDR   <= {4'b0000, ADDR};
            SRAM_DQ_out <= Data_from_CPU;
            ub_en       <= ~Mem_UB;
            lb_en       <= ~Mem_LB;
         end
         if (accept && !wr_req && io_hit)
            Data_to_CPU <= Switches;
         else if ((state == RD_ACC) && (state_nx == DONE))
            Data_to_CPU <= SRAM_DQ_in;
`ifdef IO_HEX_EN
         if (accept && wr_req && io_wr)
            HEX_out <= Data_from_CPU;
`endif
         if ((state != IDLE) && any_req)
            Req_dropped <= 1'b1;
         Mem_ready  <= (state != DONE) && (state_nx == DONE);
         SRAM_CE_N  <= ~active_nx;
         SRAM_OE_N  <= (state_nx != RD_ACC);
         SRAM_WE_N  <= (state_nx != WR_PULSE);
         SRAM_DQ_oe <= active_nx && (state_nx != RD_ACC);
         SRAM_UB_N  <= ~(active_nx & ub_sel);
         SRAM_LB_N  <= ~(active_nx & lb_sel);
      end
   end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: directed transactions into mem_bus_ctrl; a negedge monitor scores each
// Mem_ready pulse against the queued expectation. Honours IO_HEX_EN when defined.
module tb_mem_bus_ctrl;

   localparam int TB_WAIT = 1;
   localparam int RD_LAT  = TB_WAIT + 2;
   localparam int WR_LAT  = TB_WAIT + 4;

   logic        Clk;
   logic        Reset_n;
   logic        Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB;
   logic [15:0] ADDR, Data_from_CPU, Switches;
   logic [15:0] Data_to_CPU;
   logic        Mem_ready, Busy, Req_dropped;
   logic [19:0] SRAM_ADDR;
   logic [15:0] SRAM_DQ_in, SRAM_DQ_out;
   logic        SRAM_DQ_oe, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N;
`ifdef IO_HEX_EN
   logic [15:0] HEX_out;
`endif

   mem_bus_ctrl #(.WAIT_CYCLES(TB_WAIT), .IO_ADDR(16'hFFFF)) dut (
      .Clk(Clk), .Reset_n(Reset_n),
      .Mem_CE(Mem_CE), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .Mem_UB(Mem_UB), .Mem_LB(Mem_LB),
      .ADDR(ADDR), .Data_from_CPU(Data_from_CPU), .Switches(Switches),
      .Data_to_CPU(Data_to_CPU), .Mem_ready(Mem_ready), .Busy(Busy), .Req_dropped(Req_dropped),
      .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ_in(SRAM_DQ_in), .SRAM_DQ_out(SRAM_DQ_out),
      .SRAM_DQ_oe(SRAM_DQ_oe), .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N),
      .SRAM_WE_N(SRAM_WE_N), .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N)
`ifdef IO_HEX_EN
      , .HEX_out(HEX_out)
`endif
   );

   typedef struct {
      int          issue;
      int          lat;
      logic [15:0] data;
      logic [19:0] addr;
      logic [15:0] dq;
      int          ce, oe, we, dqoe, ub, lb, we_first;
   } exp_t;

   exp_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;

   // Monitor window, cleared after every completion and during reset
   int          busy_cnt, ce_cnt, oe_cnt, we_cnt, dqoe_cnt, ub_cnt, lb_cnt, we_first;
   logic        overlap, addr_bad, dq_bad;
   logic [19:0] addr_seen;
   logic [15:0] dq_seen;
   exp_t        mon_e;

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   always @(posedge Clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic clear_window();
      busy_cnt = 0; ce_cnt = 0; oe_cnt = 0; we_cnt = 0; dqoe_cnt = 0;
      ub_cnt = 0; lb_cnt = 0; we_first = 0;
      overlap = 1'b0; addr_bad = 1'b0; dq_bad = 1'b0;
      addr_seen = '0; dq_seen = '0;
   endtask

   function automatic exp_t exp_rd(input logic [19:0] addr, input logic [15:0] data,
                                   input logic ub, input logic lb);
      exp_t e;
      e.issue = 0; e.lat = RD_LAT; e.data = data; e.addr = addr; e.dq = '0;
      e.ce = TB_WAIT + 1; e.oe = TB_WAIT + 1; e.we = 0; e.dqoe = 0;
      e.ub = ub ? TB_WAIT + 1 : 0; e.lb = lb ? TB_WAIT + 1 : 0; e.we_first = 0;
      return e;
   endfunction

   function automatic exp_t exp_wr(input logic [19:0] addr, input logic [15:0] dq,
                                   input logic [15:0] held, input logic ub, input logic lb);
      exp_t e;
      e.issue = 0; e.lat = WR_LAT; e.data = held; e.addr = addr; e.dq = dq;
      e.ce = TB_WAIT + 3; e.oe = 0; e.we = TB_WAIT + 1; e.dqoe = TB_WAIT + 3;
      e.ub = ub ? TB_WAIT + 3 : 0; e.lb = lb ? TB_WAIT + 3 : 0; e.we_first = 2;
      return e;
   endfunction

   function automatic exp_t exp_io(input logic [15:0] data);
      exp_t e;
      e.issue = 0; e.lat = 1; e.data = data; e.addr = '0; e.dq = '0;
      e.ce = 0; e.oe = 0; e.we = 0; e.dqoe = 0; e.ub = 0; e.lb = 0; e.we_first = 0;
      return e;
   endfunction

   always @(negedge Clk) begin
      if (!Reset_n) begin
         clear_window();
      end else begin
         if (Busy) busy_cnt++;
         if (!SRAM_CE_N) begin
            ce_cnt++;
            if (ce_cnt == 1) addr_seen = SRAM_ADDR;
            else if (SRAM_ADDR !== addr_seen) addr_bad = 1'b1;
         end
         if (!SRAM_OE_N) oe_cnt++;
         if (!SRAM_WE_N) begin
            we_cnt++;
            if (we_cnt == 1) we_first = ce_cnt;
         end
         if (!SRAM_OE_N && !SRAM_WE_N) overlap = 1'b1;
         if (SRAM_DQ_oe) begin
            dqoe_cnt++;
            if (dqoe_cnt == 1) dq_seen = SRAM_DQ_out;
            else if (SRAM_DQ_out !== dq_seen) dq_bad = 1'b1;
         end
         if (!SRAM_UB_N) ub_cnt++;
         if (!SRAM_LB_N) lb_cnt++;
         if (Mem_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_ready", 32'd1, 32'd0);
            end else begin
               mon_e = sb.pop_front();
               chk("latency", cyc - mon_e.issue, mon_e.lat);
               chk("data_to_cpu", Data_to_CPU, mon_e.data);
               chk("busy_cycles", busy_cnt, mon_e.lat);
               chk("ce_cycles", ce_cnt, mon_e.ce);
               chk("oe_cycles", oe_cnt, mon_e.oe);
               chk("we_cycles", we_cnt, mon_e.we);
               chk("we_first", we_first, mon_e.we_first);
               chk("dqoe_cycles", dqoe_cnt, mon_e.dqoe);
               chk("ub_cycles", ub_cnt, mon_e.ub);
               chk("lb_cycles", lb_cnt, mon_e.lb);
               chk("oe_we_overlap", overlap, 1'b0);
               chk("pins_idle_at_ready",
                   {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N, SRAM_DQ_oe}, 6'b111110);
               if (mon_e.ce > 0) begin
                  chk("sram_addr", addr_seen, mon_e.addr);
                  chk("sram_addr_stable", addr_bad, 1'b0);
               end
               if (mon_e.dqoe > 0) begin
                  chk("dq_out", dq_seen, mon_e.dq);
                  chk("dq_out_stable", dq_bad, 1'b0);
               end
            end
            clear_window();
         end
      end
   end

   task automatic release_bus();
      Mem_CE = 1'b1; Mem_OE = 1'b1; Mem_WE = 1'b1; Mem_UB = 1'b1; Mem_LB = 1'b1;
   endtask

   task automatic drive(input logic rd, input logic wr, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic ub_n, input logic lb_n);
      Mem_CE = 1'b0; Mem_OE = ~rd; Mem_WE = ~wr; Mem_UB = ub_n; Mem_LB = lb_n;
      ADDR = addr; Data_from_CPU = wdata;
   endtask

   // Strobes stay low through completion, as the control unit would hold them
   task automatic apply_stimulus(input logic rd, input logic wr, input logic [15:0] addr,
                                 input logic [15:0] wdata, input logic ub_n, input logic lb_n,
                                 input exp_t e);
      @(negedge Clk);
      drive(rd, wr, addr, wdata, ub_n, lb_n);
      e.issue = cyc;
      sb.push_back(e);
      repeat (e.lat) @(negedge Clk);
      release_bus();
      @(negedge Clk);
   endtask

   initial begin
      clear_window();
      Reset_n = 1'b0;
      release_bus();
      ADDR = '0; Data_from_CPU = '0; Switches = '0; SRAM_DQ_in = '0;
      repeat (2) @(negedge Clk);
      chk("rst_ctrl_pins", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}, 5'b11111);
      chk("rst_dq_oe", SRAM_DQ_oe, 1'b0);
      chk("rst_addr", SRAM_ADDR, 20'h00000);
      chk("rst_dq_out", SRAM_DQ_out, 16'h0000);
      chk("rst_status", {Mem_ready, Busy, Req_dropped}, 3'b000);
      chk("rst_data", Data_to_CPU, 16'h0000);
`ifdef IO_HEX_EN
      chk("rst_hex", HEX_out, 16'h0000);
`endif
      Reset_n = 1'b1;
      @(negedge Clk);

      SRAM_DQ_in = 16'hBEEF;
      apply_stimulus(1'b1, 1'b0, 16'h0030, 16'h0000, 1'b0, 1'b0,
                     exp_rd(20'h00030, 16'hBEEF, 1'b1, 1'b1));
      apply_stimulus(1'b0, 1'b1, 16'h0102, 16'h1234, 1'b0, 1'b0,
                     exp_wr(20'h00102, 16'h1234, 16'hBEEF, 1'b1, 1'b1));
      Switches = 16'h00A5;
      apply_stimulus(1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 1'b0, exp_io(16'h00A5));
`ifdef IO_HEX_EN
      apply_stimulus(1'b0, 1'b1, 16'hFFFF, 16'hCAFE, 1'b0, 1'b0, exp_io(16'h00A5));
      chk("hex_out", HEX_out, 16'hCAFE);
`else
      apply_stimulus(1'b0, 1'b1, 16'hFFFF, 16'hCAFE, 1'b0, 1'b0,
                     exp_wr(20'h0FFFF, 16'hCAFE, 16'h00A5, 1'b1, 1'b1));
`endif
      // Both strobes falling together must run only the write
      apply_stimulus(1'b1, 1'b1, 16'h0040, 16'h5555, 1'b0, 1'b0,
                     exp_wr(20'h00040, 16'h5555, 16'h00A5, 1'b1, 1'b1));
      SRAM_DQ_in = 16'h7E7E;
      apply_stimulus(1'b1, 1'b0, 16'h0041, 16'h0000, 1'b1, 1'b0,
                     exp_rd(20'h00041, 16'h7E7E, 1'b0, 1'b1));
      apply_stimulus(1'b0, 1'b1, 16'h0042, 16'hAB00, 1'b0, 1'b1,
                     exp_wr(20'h00042, 16'hAB00, 16'h7E7E, 1'b1, 1'b0));
      chk("req_dropped_clear", Req_dropped, 1'b0);

      // Second OE edge lands on the last RD_ACC edge
      SRAM_DQ_in = 16'h1111;
      @(negedge Clk);
      drive(1'b1, 1'b0, 16'h0030, 16'h0000, 1'b0, 1'b0);
      mon_e = exp_rd(20'h00030, 16'h1111, 1'b1, 1'b1);
      mon_e.issue = cyc;
      sb.push_back(mon_e);
      @(negedge Clk);
      Mem_OE = 1'b1;
      @(negedge Clk);
      Mem_OE = 1'b0;
      @(negedge Clk);
      release_bus();
      @(negedge Clk);
      chk("req_dropped_set", Req_dropped, 1'b1);
      Switches = 16'h5A3C;
      apply_stimulus(1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 1'b0, exp_io(16'h5A3C));
      chk("req_dropped_sticky", Req_dropped, 1'b1);

      // Reset while the write pulse is active
      @(negedge Clk);
      drive(1'b0, 1'b1, 16'h0050, 16'h9999, 1'b0, 1'b0);
      repeat (2) @(negedge Clk);
      chk("pulse_before_reset", SRAM_WE_N, 1'b0);
      Reset_n = 1'b0;
      #1;
      chk("abort_we_n", SRAM_WE_N, 1'b1);
      chk("abort_dq_oe", SRAM_DQ_oe, 1'b0);
      chk("abort_status", {Mem_ready, Busy, Req_dropped}, 3'b000);
      chk("abort_data", Data_to_CPU, 16'h0000);
      release_bus();
      repeat (2) @(negedge Clk);
      Reset_n = 1'b1;
      repeat (3) @(negedge Clk);
      chk("idle_after_reset", Busy, 1'b0);

      SRAM_DQ_in = 16'h0F0F;
      apply_stimulus(1'b1, 1'b0, 16'h0060, 16'h0000, 1'b0, 1'b0,
                     exp_rd(20'h00060, 16'h0F0F, 1'b1, 1'b1));

      repeat (4) @(negedge Clk);
      chk("sb_leftover", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
